// File: rtl/bcd_timer_pkg.sv
// Shared types, constants and helpers for the BCD down-timer.
package bcd_timer_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [3:0]  BCD_MAX    = 4'd9;
  localparam int unsigned MAX_DIGITS = 16;
  localparam int unsigned PRESC_W    = 16;

  // True when every used nibble holds a decimal digit; unused upper nibbles are ignored.
  function automatic logic bcd_valid(input logic [4*MAX_DIGITS-1:0] value,
                                     input int unsigned             digits);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if ((i < digits) && (value[4*i +: 4] > BCD_MAX)) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of a ripple decrementer: subtracts borrow_i, wraps 0 -> 9 with borrow_o.
module bcd_digit_dec
  import bcd_timer_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       borrow_i,
  output logic [3:0] digit_o,
  output logic       borrow_o
);

  always_comb begin
    digit_o  = digit_i;
    borrow_o = 1'b0;
    if (borrow_i) begin
      if (digit_i == 4'd0) begin
        digit_o  = BCD_MAX;
        borrow_o = 1'b1;
      end else begin
        digit_o = digit_i - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD down-counter with prescaler and borrow-out pulse.
// Optional BCD_DOWN_TIMER_AUTO_RELOAD_EN: reload the start value on terminal tick and keep running.
module bcd_down_timer
  import bcd_timer_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [4*DIGITS-1:0] load_value,
  input  logic                pause,
  input  logic                abort,
  output logic [4*DIGITS-1:0] cnt,
  output logic                busy,
  output logic                bout,
  output logic                err
);

  localparam int unsigned        CNT_W      = 4 * DIGITS;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               bout_q, bout_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
  logic [CNT_W-1:0]   reload_q, reload_d;
`endif

  logic [CNT_W-1:0]   dec_cnt;
  logic [CNT_W-1:0]   next_cnt;
  logic [DIGITS:0]    borrow;

  // Ripple decrement chain; the LSD always receives the decrement request.
  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_dec u_digit (
      .digit_i  (cnt_q[4*g +: 4]),
      .borrow_i (borrow[g]),
      .digit_o  (dec_cnt[4*g +: 4]),
      .borrow_o (borrow[g+1])
    );
  end

  // A borrow out of the MSD would mean wrapping below zero; saturate instead.
  assign next_cnt = borrow[DIGITS] ? '0 : dec_cnt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    bout_d  = 1'b0;
    err_d   = 1'b0;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_valid && ready_q) begin
          if (!bcd_valid((4*MAX_DIGITS)'(load_value), DIGITS)) begin
            err_d = 1'b1;
          end else if (load_value == '0) begin
            cnt_d  = '0;
            bout_d = 1'b1;
          end else begin
            cnt_d   = load_value;
            presc_d = '0;
            state_d = RUN;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
            reload_d = load_value;
`endif
          end
        end
      end
      RUN: begin
        if (abort) begin
          cnt_d   = '0;
          presc_d = '0;
          state_d = IDLE;
        end else if (!pause) begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            cnt_d   = next_cnt;
            if (next_cnt == '0) begin
              bout_d = 1'b1;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
              cnt_d = reload_q;
`else
              state_d = IDLE;
`endif
            end
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d == RUN);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      presc_q <= '0;
      bout_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      bout_q  <= bout_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign cnt        = cnt_q;
  assign busy       = busy_q;
  assign bout       = bout_q;
  assign err        = err_q;
  assign load_ready = ready_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Scoreboard bench for bcd_down_timer: TICK_DIV=1 and TICK_DIV=3 instances against a decimal model.
module tb_bcd_down_timer;

  logic        clk = 1'b0;
  logic        rst, pause, abort, lv1, lv3;
  logic [15:0] load_value;
  logic        rdy1, busy1, bout1, err1, rdy3, busy3, bout3, err3;
  logic [15:0] cnt1, cnt3;

  always #5 clk = ~clk;

  bcd_down_timer #(.DIGITS(4), .TICK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .load_valid(lv1), .load_ready(rdy1), .load_value(load_value),
    .pause(pause), .abort(abort), .cnt(cnt1), .busy(busy1), .bout(bout1), .err(err1));

  bcd_down_timer #(.DIGITS(4), .TICK_DIV(3)) u_dut3 (
    .clk(clk), .rst(rst), .load_valid(lv3), .load_ready(rdy3), .load_value(load_value),
    .pause(pause), .abort(abort), .cnt(cnt3), .busy(busy3), .bout(bout3), .err(err3));

  typedef struct packed {
    logic [15:0] cnt;
    logic        busy;
    logic        bout;
    logic        err;
    logic        rdy;
  } obs_t;

  obs_t exp_q[$];
  obs_t obs;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   sel   = 1'b0;

  bit m_run, m_bout, m_err;
  int m_cnt, m_presc;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
  int m_reload;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, td=%0d)", tag, got, exp, cyc, sel ? 3 : 1);
    end
  endtask

  function automatic int from_bcd(input logic [15:0] v);
    int r = 0;
    for (int k = 3; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x = v;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit nib_ok(input logic [15:0] v);
    for (int k = 0; k < 4; k++) if (v[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Decimal reference model advanced once per clock edge.
  task automatic model_step();
    int td = sel ? 3 : 1;
    bit lv = sel ? lv3 : lv1;
    if (rst) begin
      m_run = 0; m_cnt = 0; m_presc = 0; m_bout = 0; m_err = 0;
      return;
    end
    m_bout = 0;
    m_err  = 0;
    if (!m_run) begin
      if (lv) begin
        if (!nib_ok(load_value)) m_err = 1;
        else if (load_value == 16'h0) begin
          m_cnt = 0; m_bout = 1;
        end else begin
          m_cnt = from_bcd(load_value); m_presc = 0; m_run = 1;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
          m_reload = m_cnt;
`endif
        end
      end
    end else if (abort) begin
      m_run = 0; m_cnt = 0;
    end else if (!pause) begin
      if (m_presc == td - 1) begin
        m_presc = 0;
        m_cnt   = m_cnt - 1;
        if (m_cnt == 0) begin
          m_bout = 1;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
          m_cnt = m_reload;
`else
          m_run = 0;
`endif
        end
      end else begin
        m_presc = m_presc + 1;
      end
    end
  endtask

  task automatic step();
    obs_t e;
    model_step();
    exp_q.push_back({to_bcd(m_cnt), m_run, m_bout, m_err, ~m_run});
    @(posedge clk);
    #1;
    cyc++;
    obs = sel ? {cnt3, busy3, bout3, err3, rdy3} : {cnt1, busy1, bout1, err1, rdy1};
    e = exp_q.pop_front();
    check("cnt",  32'(obs.cnt),  32'(e.cnt));
    check("busy", 32'(obs.busy), 32'(e.busy));
    check("bout", 32'(obs.bout), 32'(e.bout));
    check("err",  32'(obs.err),  32'(e.err));
    check("rdy",  32'(obs.rdy),  32'(e.rdy));
  endtask

  task automatic load(input logic [15:0] v);
    load_value = v;
    if (sel) lv3 = 1'b1; else lv1 = 1'b1;
    step();
    lv1 = 1'b0;
    lv3 = 1'b0;
  endtask

  task automatic wait_bout(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (obs.bout) return;
    end
    check("bout_timeout", 32'd0, 32'd1);
  endtask

  // Leaves an auto-reloading run; harmless in IDLE.
  task automatic stop_run();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  initial begin
    int t0;
    int nb;
    rst = 1'b1; pause = 1'b0; abort = 1'b0; lv1 = 1'b0; lv3 = 1'b0; load_value = 16'h0;
    step(); step();
    rst = 1'b0;
    step();

    // TICK_DIV=1: 12 down to 0
    load(16'h0012); t0 = cyc;
    wait_bout(100);
    check("lat_0012", 32'(cyc - t0), 32'd12);
    stop_run();

    // Multi-digit borrow path
    load(16'h1000); t0 = cyc;
    wait_bout(1100);
    check("lat_1000", 32'(cyc - t0), 32'd1000);
    stop_run();

    load(16'h00A5); step(); step();
    load(16'h9F00); step();
    load(16'h0000); step(); step();

    // Abort mid-count and on the terminal tick
    load(16'h0005); step(); step();
    stop_run(); step();
    load(16'h0003); step(); step();
    abort = 1'b1; step(); abort = 1'b0;
    check("abort_term_bout", 32'(obs.bout), 32'd0);
    check("abort_term_cnt", 32'(obs.cnt), 32'd0);
    step(); step();
    abort = 1'b1; step(); abort = 1'b0;

    // Loads offered during RUN are ignored
    load(16'h0020);
    lv1 = 1'b1; load_value = 16'h0050;
    for (int i = 0; i < 4; i++) step();
    lv1 = 1'b0;
    wait_bout(40);
    stop_run();

    // Reset mid-count
    load(16'h0050);
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    step(); step();

    // Switch to the TICK_DIV=3 instance
    sel = 1'b1;
    rst = 1'b1; step(); rst = 1'b0; step();
    load(16'h0100); t0 = cyc;
    for (int i = 0; i < 10 && obs.cnt == 16'h0100; i++) step();
    check("first_dec_lat", 32'(cyc - t0), 32'd3);
    check("first_dec_val", 32'(obs.cnt), 32'h0099);
    wait_bout(400);
    check("lat_0100", 32'(cyc - t0), 32'd300);
    stop_run();

    // Pause for 5 cycles mid-count
    load(16'h0010); t0 = cyc;
    for (int i = 0; i < 7; i++) step();
    pause = 1'b1;
    for (int i = 0; i < 5; i++) step();
    pause = 1'b0;
    wait_bout(100);
    check("lat_pause", 32'(cyc - t0), 32'd35);
    stop_run();

    load(16'h00A5); step();
    load(16'h0000); step();

`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
    sel = 1'b0;
    rst = 1'b1; step(); rst = 1'b0; step();
    load(16'h0003);
    nb = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (obs.bout) nb++;
    end
    check("reload_bouts", 32'(nb), 32'd3);
    check("reload_busy", 32'(obs.busy), 32'd1);
    stop_run();
    check("reload_abort_busy", 32'(obs.busy), 32'd0);
`else
    nb = 0;
`endif
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
